// File: rtl/mem_wb_stage.sv
// Memory stage with MEM/WB pipeline latch: one data request per load/store, dhit handshake.
// Optional MEM_WB_FWD_EN adds the fwd_en/fwd_reg/fwd_dat forwarding taps.
module mem_wb_stage #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5,
    parameter int SEL_W  = 3
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              flush,
    input  logic              memRd,
    input  logic              memWr,
    input  logic              halt_in,
    input  logic              regWr_in,
    input  logic [SEL_W-1:0]  regSel_in,
    input  logic [REG_W-1:0]  regDst_in,
    input  logic [WORD_W-1:0] nPC_in,
    input  logic [WORD_W-1:0] ALUOut_in,
    input  logic [WORD_W-1:0] lui_in,
    input  logic [WORD_W-1:0] storeData,
    input  logic [WORD_W-1:0] dmemload_in,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              regWr,
    output logic [SEL_W-1:0]  regSel,
    output logic [REG_W-1:0]  regDst,
    output logic [WORD_W-1:0] nPC,
    output logic [WORD_W-1:0] ALUOut,
    output logic [WORD_W-1:0] lui,
    output logic [WORD_W-1:0] dmemload,
`ifdef MEM_WB_FWD_EN
    output logic              fwd_en,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [WORD_W-1:0] fwd_dat,
`endif
    output logic              halt
);

    localparam logic [SEL_W-1:0] SEL_ALU = 3'd0;
    localparam logic [SEL_W-1:0] SEL_MEM = 3'd1;
    localparam logic [SEL_W-1:0] SEL_LUI = 3'd2;
    localparam logic [SEL_W-1:0] SEL_NPC = 3'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

    state_t            state_r, state_nxt_s;
    logic [WORD_W-1:0] load_buf_r;
    logic              memop_s, req_s, advance_s;

    // Request qualification; reset gates the strobes so a lost request drops immediately.
    always_comb begin
        memop_s   = (memRd | memWr) & ~halt_in & ~halt;
        req_s     = memop_s & (state_r != DONE) & nRST;
        mem_stall = req_s & ~dhit;
        advance_s = ihit & ~mem_stall;
        dmemWEN   = req_s & memWr;
        dmemREN   = req_s & memRd & ~memWr;
        dmemaddr  = ALUOut_in;
        dmemstore = storeData;
    end

    // Next-state logic: a retired request parks in DONE until the pipeline advances.
    always_comb begin
        state_nxt_s = state_r;
        if (advance_s) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = memop_s ? (dhit ? DONE : WAIT) : IDLE;
                WAIT:    state_nxt_s = dhit ? DONE : WAIT;
                DONE:    state_nxt_s = DONE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // FSM state and load capture buffer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r    <= IDLE;
            load_buf_r <= {WORD_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (dhit && memRd) begin
                load_buf_r <= dmemload_in;
            end
        end
    end

    // MEM/WB latch; flush inserts a bubble but never clears an already-latched halt.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            regWr    <= 1'b0;
            regSel   <= {SEL_W{1'b0}};
            regDst   <= {REG_W{1'b0}};
            nPC      <= {WORD_W{1'b0}};
            ALUOut   <= {WORD_W{1'b0}};
            lui      <= {WORD_W{1'b0}};
            dmemload <= {WORD_W{1'b0}};
            halt     <= 1'b0;
        end else if (advance_s) begin
            halt <= halt | (~flush & halt_in);
            if (flush) begin
                regWr    <= 1'b0;
                regSel   <= {SEL_W{1'b0}};
                regDst   <= {REG_W{1'b0}};
                nPC      <= {WORD_W{1'b0}};
                ALUOut   <= {WORD_W{1'b0}};
                lui      <= {WORD_W{1'b0}};
                dmemload <= {WORD_W{1'b0}};
            end else begin
                regWr    <= regWr_in;
                regSel   <= regSel_in;
                regDst   <= regDst_in;
                nPC      <= nPC_in;
                ALUOut   <= ALUOut_in;
                lui      <= lui_in;
                dmemload <= dhit ? dmemload_in : load_buf_r;
            end
        end
    end

`ifdef MEM_WB_FWD_EN
    // Forwarding tap: same data the write-back mux will select.
    always_comb begin
        fwd_en  = regWr;
        fwd_reg = regDst;
        case (regSel)
            SEL_ALU: fwd_dat = ALUOut;
            SEL_MEM: fwd_dat = dmemload;
            SEL_LUI: fwd_dat = lui;
            SEL_NPC: fwd_dat = nPC;
            default: fwd_dat = ALUOut;
        endcase
    end
`endif

endmodule
